// File: rtl/img_pkg.sv
// Shared image geometry defaults and counter sizing
// for the 3x3 window generator.
package img_pkg;

  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int DW_DEF    = 8;

  localparam int COL_W_DEF = $clog2(IMG_W_DEF);
  localparam int ROW_W_DEF = $clog2(IMG_H_DEF);

  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lb_ram.sv
// One line of pixel storage: asynchronous read,
// synchronous write, contents survive reset.
module lb_ram
  import img_pkg::*;
#(
  parameter int DEPTH = IMG_W_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/window_3x3.sv
// Raster-order 3x3 sliding window with two line
// buffers and valid/ready handshakes on both sides.
module window_3x3
  import img_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          clk_i_w,
  input  logic          rst_i_w,
  input  logic [DW-1:0] pix_i,
  input  logic          pix_valid_i,
  output logic          pix_ready_o,
  output logic [DW-1:0] data_o_0,
  output logic [DW-1:0] data_o_1,
  output logic [DW-1:0] data_o_2,
  output logic [DW-1:0] data_o_3,
  output logic [DW-1:0] data_o_4,
  output logic [DW-1:0] data_o_5,
  output logic [DW-1:0] data_o_6,
  output logic [DW-1:0] data_o_7,
  output logic [DW-1:0] data_o_8,
  output logic          win_valid_o,
  input  logic          win_ready_i,
  output logic          frame_done_o
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic          win_valid_q;
  logic          frame_done_q;
  logic [DW-1:0] win_q [9];
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;

  logic accept;
  logic col_end;
  logic row_end;
  logic win_done;

  assign pix_ready_o = !win_valid_q || win_ready_i;
  assign accept      = pix_valid_i && pix_ready_o;
  assign col_end     = (col_q == COL_LAST);
  assign row_end     = (row_q == ROW_LAST);
  assign win_done    = (col_q >= COL_TWO) &&
                       (row_q >= ROW_TWO);

  // lb1 takes lb0's old word in the same cycle
  lb_ram #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb0 (
    .clk   (clk_i_w),
    .we    (accept),
    .addr  (col_q),
    .wdata (pix_i),
    .rdata (lb0_rd)
  );

  lb_ram #(.DEPTH(IMG_W), .DW(DW), .AW(CW)) u_lb1 (
    .clk   (clk_i_w),
    .we    (accept),
    .addr  (col_q),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  always_ff @(posedge clk_i_w or posedge rst_i_w) begin
    if (rst_i_w) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_end) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i_w or posedge rst_i_w) begin
    if (rst_i_w) begin
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && col_end && row_end;
      if (accept && win_done)
        win_valid_q <= 1'b1;
      else if (win_ready_i)
        win_valid_q <= 1'b0;
    end
  end

  // shifts only on accept, so a pending window is held
  always_ff @(posedge clk_i_w or posedge rst_i_w) begin
    if (rst_i_w) begin
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else if (accept) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= lb1_rd;
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= lb0_rd;
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= pix_i;
    end
  end

  assign data_o_0     = win_q[0];
  assign data_o_1     = win_q[1];
  assign data_o_2     = win_q[2];
  assign data_o_3     = win_q[3];
  assign data_o_4     = win_q[4];
  assign data_o_5     = win_q[5];
  assign data_o_6     = win_q[6];
  assign data_o_7     = win_q[7];
  assign data_o_8     = win_q[8];
  assign win_valid_o  = win_valid_q;
  assign frame_done_o = frame_done_q;

endmodule
